// File: rtl/la_pkg.sv
// Shared logic-analyzer definitions: capture FSM states and data-path constants.
package la_pkg;

  localparam int unsigned LA_BYTE_W  = 8;
  localparam int unsigned LA_DET_MAX = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_t;

endpackage

// File: rtl/uart_capture_buffer_fifo.sv
// byte_fifo: synchronous byte FIFO with flush, registered read data and
// registered level/full/empty. Occupancy is tracked separately from the pointers.
module byte_fifo
  import la_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr,
  input  logic [LA_BYTE_W-1:0]          wr_data,
  input  logic                          rd,
  input  logic                          flush,
  output logic [LA_BYTE_W-1:0]          rd_data,
  output logic                          rd_valid,
  output logic [$clog2(DEPTH):0]        level,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  logic [LA_BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 do_rd_c;
  logic                 do_wr_c;
  logic [LW-1:0]        level_nxt_c;

  // A pop frees the slot a full-FIFO write needs; a pop on empty never bypasses.
  always_comb begin
    do_rd_c     = rd && !empty;
    do_wr_c     = wr && (!full || do_rd_c);
    level_nxt_c = level + LW'(do_wr_c) - LW'(do_rd_c);
  end

  always_ff @(posedge clk) begin
    if (do_wr_c && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rd_valid <= 1'b0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
    end else begin
      if (do_wr_c) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (do_rd_c) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + PW'(1);
      end
      rd_valid <= do_rd_c;
      level    <= level_nxt_c;
      full     <= (level_nxt_c == LW'(DEPTH));
      empty    <= (level_nxt_c == '0);
    end
  end

endmodule

// File: rtl/uart_capture_buffer.sv
// Capture stage after the UART decoder: arm/trigger FSM feeding a byte FIFO,
// plus a saturating frame-detect counter and sticky overflow flag.
module uart_capture_buffer
  import la_pkg::*;
#(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned CAPTURE_LEN = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [LA_BYTE_W-1:0]   in_data,
  input  logic                   in_valid,
  input  logic                   in_detected,
  input  logic                   arm,
  input  logic                   trig_en,
  input  logic [LA_BYTE_W-1:0]   trig_byte,
  input  logic                   rd_en,
  output logic [LA_BYTE_W-1:0]   rd_data,
  output logic                   rd_valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   busy,
  output logic                   done,
  output logic                   triggered,
  output logic                   overflow,
  output logic [7:0]             det_count
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CAP_LEN = CW'(CAPTURE_LEN);
  localparam logic [7:0]    DET_MAX = 8'(LA_DET_MAX);

  cap_state_t           state_q;
  cap_state_t           state_d;
  logic [CW-1:0]        cnt_q;
  logic [CW-1:0]        cnt_d;
  logic [LA_BYTE_W-1:0] trig_q;
  logic                 wr_c;
  logic                 trig_hit_c;
  logic                 busy_d;
  logic                 done_d;

  // Next-state: arm wins over everything; overflowed bytes still count toward the window.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wr_c       = 1'b0;
    trig_hit_c = 1'b0;
    if (arm) begin
      state_d = trig_en ? ARMED : CAPTURE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ARMED: begin
          if (in_valid && (in_data == trig_q)) begin
            trig_hit_c = 1'b1;
            wr_c       = 1'b1;
            cnt_d      = CW'(1);
            state_d    = (CAPTURE_LEN == 32'd1) ? DONE : CAPTURE;
          end
        end
        CAPTURE: begin
          if (in_valid) begin
            wr_c  = 1'b1;
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CAP_LEN) begin
              state_d = DONE;
            end
          end
        end
        default: ;
      endcase
    end
    busy_d = (state_d == ARMED) || (state_d == CAPTURE);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      trig_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      triggered <= 1'b0;
      overflow  <= 1'b0;
      det_count <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      done    <= done_d;
      if (arm) begin
        trig_q    <= trig_byte;
        triggered <= 1'b0;
        overflow  <= 1'b0;
        det_count <= '0;
      end else begin
        if (trig_hit_c) begin
          triggered <= 1'b1;
        end
        if (wr_c && full && !rd_en) begin
          overflow <= 1'b1;
        end
        if (in_detected && (state_q != IDLE) && (det_count != DET_MAX)) begin
          det_count <= det_count + 8'd1;
        end
      end
    end
  end

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (wr_c),
    .wr_data  (in_data),
    .rd       (rd_en && !arm),
    .flush    (arm),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .level    (level),
    .full     (full),
    .empty    (empty)
  );

endmodule

// File: tb/tb_uart_capture_buffer.sv
// Directed bench for uart_capture_buffer: a default 8/8 instance and a 4-deep,
// 6-byte instance share stimulus; each scenario checks the relevant instance.
module tb_uart_capture_buffer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_detected;
  logic       arm;
  logic       trig_en;
  logic [7:0] trig_byte;
  logic       rd_en;

  logic [7:0] a_rd_data, b_rd_data;
  logic       a_rd_valid, b_rd_valid;
  logic       a_empty, b_empty;
  logic       a_full, b_full;
  logic [3:0] a_level;
  logic [2:0] b_level;
  logic       a_busy, b_busy;
  logic       a_done, b_done;
  logic       a_triggered, b_triggered;
  logic       a_overflow, b_overflow;
  logic [7:0] a_det_count, b_det_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_capture_buffer #(.DEPTH(8), .CAPTURE_LEN(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_detected(in_detected), .arm(arm), .trig_en(trig_en), .trig_byte(trig_byte),
    .rd_en(rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .empty(a_empty),
    .full(a_full), .level(a_level), .busy(a_busy), .done(a_done),
    .triggered(a_triggered), .overflow(a_overflow), .det_count(a_det_count)
  );

  uart_capture_buffer #(.DEPTH(4), .CAPTURE_LEN(6)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_detected(in_detected), .arm(arm), .trig_en(trig_en), .trig_byte(trig_byte),
    .rd_en(rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .empty(b_empty),
    .full(b_full), .level(b_level), .busy(b_busy), .done(b_done),
    .triggered(b_triggered), .overflow(b_overflow), .det_count(b_det_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_arm(input logic te, input logic [7:0] tb);
    arm       = 1'b1;
    trig_en   = te;
    trig_byte = tb;
    tick();
    arm = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (a_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %0h exp 0", a_rd_data); end
    checks++; if (a_rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %0b exp 0", a_rd_valid); end
    checks++; if (a_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0b exp 1", a_empty); end
    checks++; if (a_full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b exp 0", a_full); end
    checks++; if (a_level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", a_level); end
    checks++; if ({a_busy, a_done, a_triggered, a_overflow} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %4b exp 0000", {a_busy, a_done, a_triggered, a_overflow});
    end
    // IDLE ignores both bytes and frame pulses
    in_detected = 1'b1;
    send(8'h99);
    in_detected = 1'b0;
    checks++; if (a_level !== 4'd0) begin errors++; $display("FAIL idle_write got level %0d exp 0", a_level); end
    checks++; if (a_det_count !== 8'd0) begin errors++; $display("FAIL idle_det got %0d exp 0", a_det_count); end
  endtask

  task automatic test_no_trigger();
    do_arm(1'b0, 8'h00);
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL notrig_busy got %0b exp 1", a_busy); end
    for (int i = 0; i < 7; i++) send(8'h11 + 8'(i));
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL notrig_done7 got %0b exp 0", a_done); end
    send(8'h18);
    checks++; if ({a_done, a_busy} !== 2'b10) begin errors++; $display("FAIL notrig_done8 got %2b exp 10", {a_done, a_busy}); end
    checks++; if (a_level !== 4'd8) begin errors++; $display("FAIL notrig_level got %0d exp 8", a_level); end
    checks++; if ({a_full, a_overflow} !== 2'b10) begin errors++; $display("FAIL notrig_full got %2b exp 10", {a_full, a_overflow}); end
    for (int i = 0; i < 8; i++) begin
      pop();
      checks++;
      if (a_rd_valid !== 1'b1 || a_rd_data !== 8'h11 + 8'(i)) begin
        errors++; $display("FAIL notrig_pop%0d got v=%0b d=%0h exp v=1 d=%0h", i, a_rd_valid, a_rd_data, 8'h11 + 8'(i));
      end
    end
    tick();
    checks++; if (a_rd_valid !== 1'b0 || a_rd_data !== 8'h18) begin
      errors++; $display("FAIL rd_hold got v=%0b d=%0h exp v=0 d=18", a_rd_valid, a_rd_data);
    end
    pop();
    checks++; if (a_rd_valid !== 1'b0 || a_level !== 4'd0 || a_empty !== 1'b1) begin
      errors++; $display("FAIL pop_empty got v=%0b lvl=%0d e=%0b exp v=0 lvl=0 e=1", a_rd_valid, a_level, a_empty);
    end
  endtask

  task automatic test_trigger();
    do_arm(1'b1, 8'hA5);
    checks++; if ({a_busy, a_done, a_triggered} !== 3'b100 || a_level !== 4'd0) begin
      errors++; $display("FAIL trig_arm got bdt=%3b lvl=%0d exp 100 lvl=0", {a_busy, a_done, a_triggered}, a_level);
    end
    send(8'h01);
    send(8'h02);
    checks++; if (a_level !== 4'd0 || a_triggered !== 1'b0) begin
      errors++; $display("FAIL trig_discard got lvl=%0d t=%0b exp lvl=0 t=0", a_level, a_triggered);
    end
    send(8'hA5);
    checks++; if (a_triggered !== 1'b1 || a_level !== 4'd1) begin
      errors++; $display("FAIL trig_hit got t=%0b lvl=%0d exp t=1 lvl=1", a_triggered, a_level);
    end
    send(8'h10);
    checks++; if (a_level !== 4'd2 || a_busy !== 1'b1) begin
      errors++; $display("FAIL trig_after got lvl=%0d busy=%0b exp lvl=2 busy=1", a_level, a_busy);
    end
    pop();
    checks++; if (a_rd_data !== 8'hA5) begin errors++; $display("FAIL trig_pop0 got %0h exp a5", a_rd_data); end
    pop();
    checks++; if (a_rd_data !== 8'h10) begin errors++; $display("FAIL trig_pop1 got %0h exp 10", a_rd_data); end
  endtask

  task automatic test_overflow();
    do_arm(1'b0, 8'h00);
    for (int i = 0; i < 6; i++) send(8'h21 + 8'(i));
    checks++; if ({b_full, b_overflow, b_done} !== 3'b111 || b_level !== 3'd4) begin
      errors++; $display("FAIL ovf_flags got fod=%3b lvl=%0d exp 111 lvl=4", {b_full, b_overflow, b_done}, b_level);
    end
    for (int i = 0; i < 4; i++) begin
      pop();
      checks++; if (b_rd_data !== 8'h21 + 8'(i)) begin
        errors++; $display("FAIL ovf_pop%0d got %0h exp %0h", i, b_rd_data, 8'h21 + 8'(i));
      end
    end
    checks++; if (b_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained got %0b exp 1", b_empty); end
  endtask

  task automatic test_full_rw();
    do_arm(1'b0, 8'h00);
    for (int i = 0; i < 4; i++) send(8'h31 + 8'(i));
    checks++; if (b_full !== 1'b1 || b_level !== 3'd4) begin
      errors++; $display("FAIL frw_full got f=%0b lvl=%0d exp f=1 lvl=4", b_full, b_level);
    end
    in_data  = 8'h35;
    in_valid = 1'b1;
    rd_en    = 1'b1;
    tick();
    in_valid = 1'b0;
    rd_en    = 1'b0;
    checks++; if (b_rd_valid !== 1'b1 || b_rd_data !== 8'h31) begin
      errors++; $display("FAIL frw_pop got v=%0b d=%0h exp v=1 d=31", b_rd_valid, b_rd_data);
    end
    checks++; if (b_level !== 3'd4 || b_overflow !== 1'b0 || b_busy !== 1'b1) begin
      errors++; $display("FAIL frw_level got lvl=%0d o=%0b b=%0b exp lvl=4 o=0 b=1", b_level, b_overflow, b_busy);
    end
    for (int i = 0; i < 4; i++) begin
      pop();
      checks++; if (b_rd_data !== 8'h32 + 8'(i)) begin
        errors++; $display("FAIL frw_pop%0d got %0h exp %0h", i, b_rd_data, 8'h32 + 8'(i));
      end
    end
  endtask

  task automatic test_det_count();
    do_arm(1'b0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      in_detected = 1'b1; tick(); in_detected = 1'b0; tick();
    end
    checks++; if (a_det_count !== 8'd10) begin errors++; $display("FAIL det_10 got %0d exp 10", a_det_count); end
    for (int i = 0; i < 290; i++) begin
      in_detected = 1'b1; tick(); in_detected = 1'b0; tick();
    end
    checks++; if (a_det_count !== 8'd255 || b_det_count !== 8'd255) begin
      errors++; $display("FAIL det_sat got a=%0d b=%0d exp 255", a_det_count, b_det_count);
    end
    in_detected = 1'b1;
    do_arm(1'b0, 8'h00);
    in_detected = 1'b0;
    checks++; if (a_det_count !== 8'd0) begin errors++; $display("FAIL det_arm got %0d exp 0", a_det_count); end
  endtask

  task automatic test_arm_mid_capture();
    do_arm(1'b1, 8'h55);
    send(8'h55);
    send(8'h01);
    send(8'h02);
    checks++; if (a_level !== 4'd3 || a_triggered !== 1'b1) begin
      errors++; $display("FAIL mid_pre got lvl=%0d t=%0b exp lvl=3 t=1", a_level, a_triggered);
    end
    // Same-cycle write and pop must both be ignored by the re-arm
    in_data  = 8'h77;
    in_valid = 1'b1;
    rd_en    = 1'b1;
    do_arm(1'b0, 8'h00);
    in_valid = 1'b0;
    rd_en    = 1'b0;
    checks++; if (a_level !== 4'd0 || a_empty !== 1'b1 || a_rd_valid !== 1'b0) begin
      errors++; $display("FAIL mid_flush got lvl=%0d e=%0b v=%0b exp lvl=0 e=1 v=0", a_level, a_empty, a_rd_valid);
    end
    checks++; if ({a_triggered, a_overflow, a_busy, a_done} !== 4'b0010) begin
      errors++; $display("FAIL mid_flags got todb=%4b exp 0010", {a_triggered, a_overflow, a_busy, a_done});
    end
  endtask

  task automatic test_reset_mid();
    do_arm(1'b1, 8'h41);
    send(8'h41);
    send(8'h42);
    pop();
    checks++; if (a_rd_data !== 8'h41 || a_triggered !== 1'b1) begin
      errors++; $display("FAIL rstmid_pre got d=%0h t=%0b exp d=41 t=1", a_rd_data, a_triggered);
    end
    rst_n = 1'b0;
    #1;
    checks++; if (a_rd_data !== 8'h00 || a_level !== 4'd0 || a_empty !== 1'b1 || a_full !== 1'b0 || a_rd_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_fifo got d=%0h lvl=%0d e=%0b f=%0b v=%0b exp 0/0/1/0/0",
                         a_rd_data, a_level, a_empty, a_full, a_rd_valid);
    end
    checks++; if ({a_busy, a_done, a_triggered, a_overflow} !== 4'b0000 || a_det_count !== 8'd0) begin
      errors++; $display("FAIL rstmid_flags got %4b det=%0d exp 0000 det=0",
                         {a_busy, a_done, a_triggered, a_overflow}, a_det_count);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n       = 1'b0;
    in_data     = 8'h00;
    in_valid    = 1'b0;
    in_detected = 1'b0;
    arm         = 1'b0;
    trig_en     = 1'b0;
    trig_byte   = 8'h00;
    rd_en       = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    test_reset();
    test_no_trigger();
    test_trigger();
    test_overflow();
    test_full_rw();
    test_det_count();
    test_arm_mid_capture();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
